// File: rtl/pia_bus_master_if.sv
// Command, response and PIA bus signals of pia_bus_master grouped into one
// bundle. The master modport is the block itself; the slave modport is the
// environment that issues commands, consumes responses and answers bus
// accesses.
interface pia_bus_master_if;
  // command channel
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [1:0] cmd_op_i;
  logic [6:0] cmd_adr_i;
  logic [7:0] cmd_dat_i;

  // response channel
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [7:0] rsp_dat_o;
  logic       rsp_err_o;

  // PIA responder bus
  logic       stb_o;
  logic       we_o;
  logic [6:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;

  // status
  logic       busy_o;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_dat_i,
    input  rsp_ready_i, dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output stb_o, we_o, adr_o, dat_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_dat_i,
    output rsp_ready_i, dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  stb_o, we_o, adr_o, dat_o, busy_o
  );
endinterface

// File: rtl/pia_bus_master.sv
// pia_bus_master: turns single commands (write, read, timer-wait) into
// strobed accesses on a simple PIA register bus and returns one response per
// command. A timer-wait loads one of the four timer registers and then polls
// INSTAT until bit 7 is set or the poll limit is reached.
module pia_bus_master #(
  parameter int unsigned POLL_GAP   = 4,       // idle cycles before each INSTAT poll (1..255)
  parameter int unsigned POLL_LIMIT = 16'hFFFF // polls before a timer-wait fails (1..65535)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pia_bus_master_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE,
    WR,
    RD,
    RD_CAP,
    TW_WR,
    TW_GAP,
    TW_RD,
    TW_CAP,
    RESP
  } state_t;

  localparam logic [1:0]  OP_WR      = 2'b00;
  localparam logic [1:0]  OP_RD      = 2'b01;
  localparam logic [1:0]  OP_TW      = 2'b10;
  localparam logic [6:0]  INSTAT_ADR = 7'h05;
  // Timer registers live at 0x14..0x17, i.e. address bits [6:2] == 5'b00101.
  localparam logic [4:0]  TIMER_PAGE = 5'b00101;
  localparam logic [7:0]  GAP_LAST   = 8'(POLL_GAP - 1);
  localparam logic [15:0] LIMIT      = 16'(POLL_LIMIT);

  state_t      state;
  logic [7:0]  gap_cnt;
  logic [15:0] poll_cnt;
  logic [15:0] poll_next;
  logic        timer_adr;

  // Ready and busy are pure decodes of the registered state, so they change
  // only on clock edges (and immediately on reset, which forces IDLE).
  assign bus.cmd_ready_o = (state == IDLE);
  assign bus.busy_o      = (state != IDLE);

  assign poll_next = poll_cnt + 16'd1;
  assign timer_adr = (bus.cmd_adr_i[6:2] == TIMER_PAGE);

  // Command sequencer: state, poll/gap counters and every registered output.
  // NOTE: all state here uses <= so each register samples values from before
  // the edge; a blocking = would let later statements see same-cycle updates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      poll_cnt        <= '0;
      bus.stb_o       <= 1'b0;
      bus.we_o        <= 1'b0;
      bus.adr_o       <= '0;
      bus.dat_o       <= '0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_dat_o   <= '0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      // A strobe lasts one cycle: drop it unless a transition below raises it
      // for the next state. adr_o/dat_o keep their last driven value.
      bus.stb_o <= 1'b0;
      bus.we_o  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            // The command fields are latched straight into the bus registers,
            // which then hold them for the whole command.
            if (bus.cmd_op_i == OP_WR) begin
              state     <= WR;
              bus.stb_o <= 1'b1;
              bus.we_o  <= 1'b1;
              bus.adr_o <= bus.cmd_adr_i;
              bus.dat_o <= bus.cmd_dat_i;
            end else if (bus.cmd_op_i == OP_RD) begin
              state     <= RD;
              bus.stb_o <= 1'b1;
              bus.adr_o <= bus.cmd_adr_i;
            end else if (bus.cmd_op_i == OP_TW && timer_adr) begin
              state     <= TW_WR;
              bus.stb_o <= 1'b1;
              bus.we_o  <= 1'b1;
              bus.adr_o <= bus.cmd_adr_i;
              bus.dat_o <= bus.cmd_dat_i;
            end else begin
              // Reserved op or timer-wait outside the timer page: fail at
              // once without touching the bus.
              state           <= RESP;
              bus.rsp_valid_o <= 1'b1;
              bus.rsp_dat_o   <= '0;
              bus.rsp_err_o   <= 1'b1;
            end
          end
        end

        WR: begin
          state           <= RESP;
          bus.rsp_valid_o <= 1'b1;
          bus.rsp_dat_o   <= '0;
          bus.rsp_err_o   <= 1'b0;
        end

        RD: begin
          // Responder presents read data during the cycle after the strobe.
          state <= RD_CAP;
        end

        RD_CAP: begin
          state           <= RESP;
          bus.rsp_valid_o <= 1'b1;
          bus.rsp_dat_o   <= bus.dat_i;
          bus.rsp_err_o   <= 1'b0;
        end

        TW_WR: begin
          state    <= TW_GAP;
          poll_cnt <= '0;
          gap_cnt  <= '0;
        end

        TW_GAP: begin
          // Stay exactly POLL_GAP cycles, then strobe an INSTAT read.
          if (gap_cnt == GAP_LAST) begin
            state     <= TW_RD;
            bus.stb_o <= 1'b1;
            bus.adr_o <= INSTAT_ADR;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        TW_RD: begin
          state <= TW_CAP;
        end

        TW_CAP: begin
          if (bus.dat_i[7]) begin
            state           <= RESP;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_dat_o   <= bus.dat_i;
            bus.rsp_err_o   <= 1'b0;
          end else if (poll_next == LIMIT) begin
            // Counter stops here, so it can never pass the limit.
            state           <= RESP;
            poll_cnt        <= poll_next;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_dat_o   <= bus.dat_i;
            bus.rsp_err_o   <= 1'b1;
          end else begin
            state    <= TW_GAP;
            poll_cnt <= poll_next;
            gap_cnt  <= '0;
          end
        end

        RESP: begin
          // Response fields hold until taken; the following cycle is IDLE,
          // so no command can be accepted in the hand-off cycle itself.
          if (bus.rsp_ready_i) begin
            state           <= IDLE;
            bus.rsp_valid_o <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pia_bus_master.sv
// Testbench for pia_bus_master: a PIA responder with its own register file,
// a bus monitor logging every strobe, and a command-level reference model
// that predicts the bus accesses, their timing and the response.
module tb_pia_bus_master;

  localparam int unsigned POLL_GAP   = 4;
  localparam int unsigned POLL_LIMIT = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pia_bus_master_if bus_if ();

  pia_bus_master #(
    .POLL_GAP   (POLL_GAP),
    .POLL_LIMIT (POLL_LIMIT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  typedef struct packed {
    logic       we;
    logic [6:0] adr;
    logic [7:0] dat;
  } acc_t;

  int          checks = 0;
  int          errors = 0;

  acc_t        bus_log[$];
  int unsigned log_cyc[$];
  int unsigned cyc       = 0;
  logic        prev_stb  = 1'b0;
  logic        b2b_seen  = 1'b0;

  logic [7:0]  resp_mem  [128];
  logic [7:0]  model_mem [128];

  // INSTAT behaviour for the current timer-wait: bit 7 rises on poll number
  // ready_at (1-based); 0 means it never rises.
  int          ready_at   = 0;
  logic [6:0]  instat_low = '0;
  int          poll_total = 0;
  int          poll_base  = 0;

  function automatic logic [7:0] instat_value(input int p);
    return (ready_at != 0 && p >= ready_at) ? {1'b1, instat_low} : {1'b0, instat_low};
  endfunction

  // Responder and bus monitor.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_stb <= bus_if.stb_o;
    if (bus_if.stb_o && prev_stb) b2b_seen <= 1'b1;
    if (bus_if.stb_o) begin
      bus_log.push_back({bus_if.we_o, bus_if.adr_o, bus_if.dat_o});
      log_cyc.push_back(cyc);
      if (bus_if.we_o)
        resp_mem[bus_if.adr_o] <= bus_if.dat_o;
      else if (bus_if.adr_o == 7'h05) begin
        poll_total    <= poll_total + 1;
        bus_if.dat_i  <= instat_value(poll_total - poll_base + 1);
      end else
        bus_if.dat_i  <= resp_mem[bus_if.adr_o];
    end
  end

  task automatic issue(input logic [1:0] op, input logic [6:0] adr, input logic [7:0] dat,
                       output int unsigned acc_cyc);
    int n = 0;
    @(negedge clk);
    while (!bus_if.cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus_if.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait: got %b want 1", bus_if.cmd_ready_o);
    end
    bus_if.cmd_valid_i = 1'b1;
    bus_if.cmd_op_i    = op;
    bus_if.cmd_adr_i   = adr;
    bus_if.cmd_dat_i   = dat;
    acc_cyc = cyc;
    @(negedge clk);
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_op_i    = $urandom_range(0, 3);
    bus_if.cmd_adr_i   = $urandom_range(0, 127);
    bus_if.cmd_dat_i   = $urandom_range(0, 255);
  endtask

  // Issue one command, predict everything from the command rules, and check
  // accesses, timing and response. hold = cycles the response is left waiting.
  task automatic run_cmd(input logic [1:0] op, input logic [6:0] adr, input logic [7:0] dat,
                         input int hold);
    acc_t        exp_acc[$];
    logic [7:0]  exp_dat;
    logic        exp_err;
    int          base;
    int          n;
    int unsigned acc_cyc;
    int unsigned first;
    int          polls;
    int          want_gap;
    logic        is_tw;

    base  = bus_log.size();
    is_tw = (op == 2'b10) && (adr >= 7'h14) && (adr <= 7'h17);
    if (op == 2'b00) begin
      exp_acc.push_back({1'b1, adr, dat});
      exp_dat = 8'h00; exp_err = 1'b0;
      model_mem[adr] = dat;
    end else if (op == 2'b01) begin
      exp_acc.push_back({1'b0, adr, 8'h00});
      exp_dat = model_mem[adr]; exp_err = 1'b0;
    end else if (is_tw) begin
      exp_acc.push_back({1'b1, adr, dat});
      model_mem[adr] = dat;
      if (ready_at != 0 && ready_at <= POLL_LIMIT) begin
        polls = ready_at; exp_dat = {1'b1, instat_low}; exp_err = 1'b0;
      end else begin
        polls = POLL_LIMIT; exp_dat = {1'b0, instat_low}; exp_err = 1'b1;
      end
      for (int i = 0; i < polls; i++) exp_acc.push_back({1'b0, 7'h05, 8'h00});
    end else begin
      exp_dat = 8'h00; exp_err = 1'b1;
    end

    poll_base = poll_total;
    issue(op, adr, dat, acc_cyc);

    n = 0;
    while (!bus_if.rsp_valid_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    first = cyc;
    checks++;
    if (bus_if.rsp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout op=%0d adr=%h: rsp_valid got %b want 1", op, adr, bus_if.rsp_valid_o);
      return;
    end

    checks++;
    if (bus_if.rsp_dat_o !== exp_dat || bus_if.rsp_err_o !== exp_err) begin
      errors++;
      $display("FAIL rsp_value op=%0d adr=%h: got dat=%h err=%b want dat=%h err=%b",
               op, adr, bus_if.rsp_dat_o, bus_if.rsp_err_o, exp_dat, exp_err);
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.rsp_valid_o !== 1'b1 || bus_if.rsp_dat_o !== exp_dat ||
          bus_if.rsp_err_o !== exp_err || bus_if.cmd_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold cycle %0d: got valid=%b dat=%h err=%b ready=%b want 1 %h %b 0",
                 i, bus_if.rsp_valid_o, bus_if.rsp_dat_o, bus_if.rsp_err_o,
                 bus_if.cmd_ready_o, exp_dat, exp_err);
      end
    end
    bus_if.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready_i = 1'b0;
    checks++;
    if (bus_if.rsp_valid_o !== 1'b0 || bus_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rsp_release: got valid=%b busy=%b want 0 0", bus_if.rsp_valid_o, bus_if.busy_o);
    end

    checks++;
    if (bus_log.size() - base != exp_acc.size()) begin
      errors++;
      $display("FAIL access_count op=%0d adr=%h: got %0d want %0d",
               op, adr, bus_log.size() - base, exp_acc.size());
      return;
    end
    for (int i = 0; i < exp_acc.size(); i++) begin
      checks++;
      if (bus_log[base+i].we !== exp_acc[i].we || bus_log[base+i].adr !== exp_acc[i].adr ||
          (exp_acc[i].we && bus_log[base+i].dat !== exp_acc[i].dat)) begin
        errors++;
        $display("FAIL access_%0d: got we=%b adr=%h dat=%h want we=%b adr=%h dat=%h", i,
                 bus_log[base+i].we, bus_log[base+i].adr, bus_log[base+i].dat,
                 exp_acc[i].we, exp_acc[i].adr, exp_acc[i].dat);
      end
    end

    // Timing: first strobe one cycle after acceptance; response one cycle
    // after a write strobe, two after a read strobe; TW_GAP lasts POLL_GAP.
    checks++;
    if (exp_acc.size() == 0) begin
      if (first != acc_cyc + 1) begin
        errors++;
        $display("FAIL immediate_rsp_timing: got %0d want %0d", first - acc_cyc, 1);
      end
    end else begin
      if (log_cyc[base] != acc_cyc + 1) begin
        errors++;
        $display("FAIL strobe_start: got %0d want %0d", log_cyc[base] - acc_cyc, 1);
      end
      for (int i = 1; i < exp_acc.size(); i++) begin
        want_gap = (i == 1) ? POLL_GAP + 1 : POLL_GAP + 2;
        checks++;
        if (log_cyc[base+i] - log_cyc[base+i-1] != want_gap) begin
          errors++;
          $display("FAIL poll_spacing_%0d: got %0d want %0d", i,
                   log_cyc[base+i] - log_cyc[base+i-1], want_gap);
        end
      end
      checks++;
      want_gap = exp_acc[exp_acc.size()-1].we ? 1 : 2;
      if (first - log_cyc[base + exp_acc.size() - 1] != want_gap) begin
        errors++;
        $display("FAIL rsp_latency: got %0d want %0d",
                 first - log_cyc[base + exp_acc.size() - 1], want_gap);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus_if.stb_o !== 1'b0 || bus_if.we_o !== 1'b0 || bus_if.adr_o !== 7'h00 ||
        bus_if.dat_o !== 8'h00 || bus_if.rsp_valid_o !== 1'b0 || bus_if.rsp_dat_o !== 8'h00 ||
        bus_if.rsp_err_o !== 1'b0 || bus_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got stb=%b we=%b adr=%h dat=%h rv=%b rd=%h re=%b busy=%b want all 0",
               bus_if.stb_o, bus_if.we_o, bus_if.adr_o, bus_if.dat_o, bus_if.rsp_valid_o,
               bus_if.rsp_dat_o, bus_if.rsp_err_o, bus_if.busy_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.cmd_ready_o !== 1'b1 || bus_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b want 1 0", bus_if.cmd_ready_o, bus_if.busy_o);
    end
  endtask

  task automatic test_write();
    run_cmd(2'b00, 7'h01, 8'hA5, 0);
  endtask

  task automatic test_read();
    resp_mem[2]  = 8'h3C;
    model_mem[2] = 8'h3C;
    run_cmd(2'b01, 7'h02, 8'h00, 1);
  endtask

  task automatic test_timer_wait();
    ready_at   = 3;
    instat_low = 7'($urandom_range(0, 127));
    run_cmd(2'b10, 7'h14, 8'h03, 0);
  endtask

  task automatic test_timeout();
    ready_at   = 0;
    instat_low = 7'h00;
    run_cmd(2'b10, 7'h17, 8'h40, 0);
  endtask

  task automatic test_invalid();
    run_cmd(2'b11, 7'h14, 8'h12, 0);
    run_cmd(2'b10, 7'h04, 8'h34, 2);
  endtask

  task automatic test_rsp_hold();
    run_cmd(2'b01, 7'h30, 8'h00, 10);
  endtask

  task automatic test_reset_mid_wait();
    int unsigned acc_cyc;
    int base;
    int n = 0;
    logic bad = 1'b0;
    ready_at = 0;
    base = bus_log.size();
    poll_base = poll_total;
    issue(2'b10, 7'h15, 8'h77, acc_cyc);
    while (bus_log.size() == base && n < 20) begin
      @(negedge clk);
      n++;
    end
    model_mem[7'h15] = 8'h77;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.busy_o !== 1'b0 || bus_if.adr_o !== 7'h00 || bus_if.dat_o !== 8'h00 ||
        bus_if.rsp_valid_o !== 1'b0 || bus_if.stb_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got busy=%b adr=%h dat=%h rv=%b stb=%b want 0",
               bus_if.busy_o, bus_if.adr_o, bus_if.dat_o, bus_if.rsp_valid_o, bus_if.stb_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.stb_o !== 1'b0 || bus_if.rsp_valid_o !== 1'b0 || bus_if.cmd_ready_o !== 1'b1)
        bad = 1'b1;
    end
    checks++;
    if (bad || bus_log.size() != base + 1) begin
      errors++;
      $display("FAIL mid_reset_abort: got activity=%b accesses=%0d want 0 1", bad, bus_log.size() - base);
    end
    run_cmd(2'b00, 7'h22, 8'h5A, 0);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [6:0] adr;
    logic [7:0] dat;
    for (int k = 0; k < 30; k++) begin
      op  = 2'($urandom_range(0, 3));
      dat = 8'($urandom_range(0, 255));
      if (op == 2'b10 && $urandom_range(0, 3) != 0) begin
        adr = 7'h14 + 7'($urandom_range(0, 3));
      end else begin
        adr = 7'($urandom_range(0, 127));
        while (adr == 7'h05 || (op == 2'b10 && adr[6:2] == 5'b00101))
          adr = 7'($urandom_range(0, 127));
      end
      ready_at   = $urandom_range(0, POLL_LIMIT + 1);
      instat_low = 7'($urandom_range(0, 127));
      run_cmd(op, adr, dat, $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    checks++;
    if (b2b_seen !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_strobe: got %b want 0", b2b_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      resp_mem[i]  = 8'($urandom_range(0, 255));
      model_mem[i] = resp_mem[i];
    end
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_op_i    = 2'b00;
    bus_if.cmd_adr_i   = 7'h00;
    bus_if.cmd_dat_i   = 8'h00;
    bus_if.rsp_ready_i = 1'b0;
    bus_if.dat_i       = 8'h00;

    test_reset();
    test_write();
    test_read();
    test_timer_wait();
    test_timeout();
    test_invalid();
    test_rsp_hold();
    test_reset_mid_wait();
    test_random();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
